// File: rtl/sym_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sym_serializer_if
// Brief    : Word-in / symbol-out handshake bundle for sym_serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface sym_serializer_if #(
  parameter int DATAWIDTH = 32,
  parameter int SYMWIDTH  = 8
);
  localparam int c_NSYM = (DATAWIDTH + SYMWIDTH - 1) / SYMWIDTH;
  localparam int c_LENW = $clog2(c_NSYM + 1);

  logic [DATAWIDTH-1:0] i_Data;
  logic [c_LENW-1:0]    i_Len;
  logic                 i_Valid;
  logic                 o_Ready;
  logic [SYMWIDTH-1:0]  o_Sym;
  logic                 o_Valid;
  logic                 o_Last;
  logic                 i_Ready;
  logic                 o_Busy;

  modport slave (
    input  i_Data, i_Len, i_Valid, i_Ready,
    output o_Ready, o_Sym, o_Valid, o_Last, o_Busy
  );

  modport master (
    output i_Data, i_Len, i_Valid, i_Ready,
    input  o_Ready, o_Sym, o_Valid, o_Last, o_Busy
  );
endinterface
`default_nettype wire

// File: rtl/sym_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sym_serializer
// Brief    : Splits a DATAWIDTH word into SYMWIDTH symbols, LSB- or MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module sym_serializer #(
  parameter int DATAWIDTH = 32,
  parameter int SYMWIDTH  = 8,
  parameter int MSB_FIRST = 0
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  sym_serializer_if.slave bus
);
  localparam int c_NSYM = (DATAWIDTH + SYMWIDTH - 1) / SYMWIDTH;
  localparam int c_LENW = $clog2(c_NSYM + 1);
  localparam int c_IDXW = (c_NSYM > 1) ? $clog2(c_NSYM) : 1;
  localparam int c_BUFW = c_NSYM * SYMWIDTH;
  localparam logic [c_LENW-1:0] c_NSYM_L = c_LENW'(c_NSYM);
  localparam logic [c_LENW-1:0] c_ONE_L  = c_LENW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_BUFW-1:0]   r_buf;
  logic [c_IDXW-1:0]   r_idx;
  logic [c_LENW-1:0]   r_rem;
  logic [SYMWIDTH-1:0] r_sym;
  logic                r_last;

  logic [c_BUFW-1:0]   w_ext;
  logic [SYMWIDTH-1:0] w_ext_syms [c_NSYM];
  logic [SYMWIDTH-1:0] w_buf_syms [c_NSYM];
  logic [c_LENW-1:0]   w_len;
  logic [c_IDXW-1:0]   w_first_idx;
  logic [c_IDXW-1:0]   w_next_idx;
  logic                w_valid;
  logic                w_ready;
  logic                w_accept;

  generate
    if (c_BUFW > DATAWIDTH) begin : g_pad
      assign w_ext = {{(c_BUFW - DATAWIDTH){1'b0}}, bus.i_Data};
    end else begin : g_nopad
      assign w_ext = bus.i_Data;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < c_NSYM; gi++) begin : g_sym
      assign w_ext_syms[gi] = w_ext[gi*SYMWIDTH +: SYMWIDTH];
      assign w_buf_syms[gi] = r_buf[gi*SYMWIDTH +: SYMWIDTH];
    end
  endgenerate

  // Zero or oversized length requests mean "the whole word".
  always_comb begin
    w_len = bus.i_Len;
    if ((bus.i_Len == '0) || (bus.i_Len > c_NSYM_L)) begin
      w_len = c_NSYM_L;
    end
  end

  assign w_first_idx = (MSB_FIRST != 0) ? c_IDXW'(w_len - c_ONE_L) : '0;
  assign w_next_idx  = (MSB_FIRST != 0) ? (r_idx - 1'b1) : (r_idx + 1'b1);

  assign w_valid  = (r_state == S_SEND);
  assign w_ready  = (r_state == S_IDLE) || (w_valid && r_last && bus.i_Ready);
  assign w_accept = bus.i_Valid && w_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_sym   <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_SEND;
      r_buf   <= w_ext;
      r_idx   <= w_first_idx;
      r_rem   <= w_len - c_ONE_L;
      r_sym   <= w_ext_syms[w_first_idx];
      r_last  <= (w_len == c_ONE_L);
    end else if (w_valid && bus.i_Ready) begin
      if (r_last) begin
        r_state <= S_IDLE;
        r_last  <= 1'b0;
      end else begin
        r_idx  <= w_next_idx;
        r_rem  <= r_rem - c_ONE_L;
        r_sym  <= w_buf_syms[w_next_idx];
        r_last <= (r_rem == c_ONE_L);
      end
    end
  end

  assign bus.o_Ready = w_ready;
  assign bus.o_Valid = w_valid;
  assign bus.o_Sym   = r_sym;
  assign bus.o_Last  = r_last;
  assign bus.o_Busy  = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_sym_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sym_serializer
// Brief    : Directed self-checking bench for sym_serializer (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sym_serializer;
  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  sym_serializer_if #(.DATAWIDTH(20), .SYMWIDTH(8)) bus_a ();
  sym_serializer_if #(.DATAWIDTH(20), .SYMWIDTH(8)) bus_b ();
  sym_serializer_if #(.DATAWIDTH(16), .SYMWIDTH(8)) bus_c ();

  sym_serializer #(.DATAWIDTH(20), .SYMWIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a)
  );

  sym_serializer #(.DATAWIDTH(20), .SYMWIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b)
  );

  sym_serializer #(.DATAWIDTH(16), .SYMWIDTH(8), .MSB_FIRST(0)) u_w16 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sym(input string tag, input logic v, input logic [7:0] s, input logic l,
                         input logic ev, input logic [7:0] es, input logic el);
    chk({tag, ".valid"}, {31'd0, v}, {31'd0, ev});
    chk({tag, ".sym"},   {24'd0, s}, {24'd0, es});
    chk({tag, ".last"},  {31'd0, l}, {31'd0, el});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    bus_a.i_Data = '0; bus_a.i_Len = '0; bus_a.i_Valid = 1'b0; bus_a.i_Ready = 1'b0;
    bus_b.i_Data = '0; bus_b.i_Len = '0; bus_b.i_Valid = 1'b0; bus_b.i_Ready = 1'b0;
    bus_c.i_Data = '0; bus_c.i_Len = '0; bus_c.i_Valid = 1'b0; bus_c.i_Ready = 1'b0;
    step(); step();

    chk_sym("rst_a", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b0, 8'h00, 1'b0);
    chk("rst_a.busy",  {31'd0, bus_a.o_Busy},  32'd0);
    chk("rst_a.ready", {31'd0, bus_a.o_Ready}, 32'd1);
    chk_sym("rst_b", bus_b.o_Valid, bus_b.o_Sym, bus_b.o_Last, 1'b0, 8'h00, 1'b0);
    chk("rst_c.ready", {31'd0, bus_c.o_Ready}, 32'd1);
    #2 rstn = 1'b1;
    step();

    // LSB-first, full length
    bus_a.i_Data = 20'h81234; bus_a.i_Len = 2'd0; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Valid = 1'b0;
    #1;
    chk_sym("lsb0", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h34, 1'b0);
    chk("lsb0.busy",  {31'd0, bus_a.o_Busy},  32'd1);
    chk("lsb0.ready", {31'd0, bus_a.o_Ready}, 32'd0);
    step();
    chk_sym("lsb1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    step();
    chk_sym("lsb2", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h08, 1'b1);
    chk("lsb2.ready", {31'd0, bus_a.o_Ready}, 32'd1);
    step();
    chk("lsb_end.valid", {31'd0, bus_a.o_Valid}, 32'd0);
    chk("lsb_end.busy",  {31'd0, bus_a.o_Busy},  32'd0);

    // MSB-first, full length
    bus_b.i_Data = 20'h81234; bus_b.i_Len = 2'd0; bus_b.i_Valid = 1'b1; bus_b.i_Ready = 1'b1;
    step();
    bus_b.i_Valid = 1'b0;
    chk_sym("msb0", bus_b.o_Valid, bus_b.o_Sym, bus_b.o_Last, 1'b1, 8'h08, 1'b0);
    step();
    chk_sym("msb1", bus_b.o_Valid, bus_b.o_Sym, bus_b.o_Last, 1'b1, 8'h12, 1'b0);
    step();
    chk_sym("msb2", bus_b.o_Valid, bus_b.o_Sym, bus_b.o_Last, 1'b1, 8'h34, 1'b1);
    step();
    chk("msb_end.valid", {31'd0, bus_b.o_Valid}, 32'd0);

    // LSB-first, length 2
    bus_a.i_Data = 20'h81234; bus_a.i_Len = 2'd2; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Valid = 1'b0;
    chk_sym("len2_0", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h34, 1'b0);
    step();
    chk_sym("len2_1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b1);
    step();
    chk("len2_end.valid", {31'd0, bus_a.o_Valid}, 32'd0);

    // Backpressure: i_Ready 1,0,0,1,1
    bus_a.i_Data = 20'h81234; bus_a.i_Len = 2'd0; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Valid = 1'b0;
    chk_sym("bp0", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h34, 1'b0);
    step();
    bus_a.i_Ready = 1'b0;
    chk_sym("bp1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    step();
    chk_sym("bp1_hold_a", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    step();
    chk_sym("bp1_hold_b", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    bus_a.i_Ready = 1'b1;
    step();
    chk_sym("bp2", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h08, 1'b1);
    step();
    chk("bp_end.valid", {31'd0, bus_a.o_Valid}, 32'd0);

    // Back-to-back words with no gap
    bus_a.i_Data = 20'h81234; bus_a.i_Len = 2'd0; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Data = 20'h12345;
    #1;
    chk_sym("b2b0", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h34, 1'b0);
    chk("b2b0.ready", {31'd0, bus_a.o_Ready}, 32'd0);
    step();
    chk_sym("b2b1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    chk("b2b1.ready", {31'd0, bus_a.o_Ready}, 32'd0);
    step();
    chk_sym("b2b2", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h08, 1'b1);
    chk("b2b2.ready", {31'd0, bus_a.o_Ready}, 32'd1);
    step();
    bus_a.i_Valid = 1'b0;
    chk_sym("b2b3", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h45, 1'b0);
    step();
    chk_sym("b2b4", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h23, 1'b0);
    step();
    chk_sym("b2b5", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h01, 1'b1);
    step();
    chk("b2b_end.valid", {31'd0, bus_a.o_Valid}, 32'd0);

    // Asynchronous reset after the 12 handshake, while 08 is pending
    bus_a.i_Data = 20'h81234; bus_a.i_Len = 2'd0; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Valid = 1'b0;
    step();
    chk_sym("rmw1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h12, 1'b0);
    step();
    bus_a.i_Ready = 1'b0;
    chk_sym("rmw2", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h08, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk_sym("rmw_rst", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b0, 8'h00, 1'b0);
    chk("rmw_rst.busy",  {31'd0, bus_a.o_Busy},  32'd0);
    chk("rmw_rst.ready", {31'd0, bus_a.o_Ready}, 32'd1);
    step();
    rstn = 1'b1;
    bus_a.i_Data = 20'h12345; bus_a.i_Valid = 1'b1; bus_a.i_Ready = 1'b1;
    step();
    bus_a.i_Valid = 1'b0;
    chk_sym("rmw_new0", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h45, 1'b0);
    step();
    chk_sym("rmw_new1", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h23, 1'b0);
    step();
    chk_sym("rmw_new2", bus_a.o_Valid, bus_a.o_Sym, bus_a.o_Last, 1'b1, 8'h01, 1'b1);
    step();
    chk("rmw_end.valid", {31'd0, bus_a.o_Valid}, 32'd0);

    // Exact-fit width, default and oversized length
    bus_c.i_Data = 16'hBEEF; bus_c.i_Len = 2'd0; bus_c.i_Valid = 1'b1; bus_c.i_Ready = 1'b1;
    step();
    bus_c.i_Valid = 1'b0;
    chk_sym("w16_0", bus_c.o_Valid, bus_c.o_Sym, bus_c.o_Last, 1'b1, 8'hEF, 1'b0);
    step();
    chk_sym("w16_1", bus_c.o_Valid, bus_c.o_Sym, bus_c.o_Last, 1'b1, 8'hBE, 1'b1);
    step();
    chk("w16_end.valid", {31'd0, bus_c.o_Valid}, 32'd0);
    bus_c.i_Len = 2'd3; bus_c.i_Valid = 1'b1;
    step();
    bus_c.i_Valid = 1'b0;
    chk_sym("w16L3_0", bus_c.o_Valid, bus_c.o_Sym, bus_c.o_Last, 1'b1, 8'hEF, 1'b0);
    step();
    chk_sym("w16L3_1", bus_c.o_Valid, bus_c.o_Sym, bus_c.o_Last, 1'b1, 8'hBE, 1'b1);
    step();
    chk("w16L3_end.valid", {31'd0, bus_c.o_Valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sym_serializer.md
# sym_serializer

Parametrised width-to-symbol serializer with ready/valid handshakes on both sides. It accepts one DATAWIDTH-bit word and emits it as a sequence of SYMWIDTH-bit symbols. Per-word length control, selectable LSB-first or MSB-first order, zero-padding of a partial top symbol, full output backpressure and bubble-free back-to-back words. It sits between wide datapath producers and byte-oriented links (UART/SPI framers, byte FIFOs).

## Interface
- DATAWIDTH, 32: input word width, ≥1.
- SYMWIDTH, 8: output symbol width, ≥1.
- MSB_FIRST, 0: 0 = symbol 0 (least significant) sent first; 1 = highest selected symbol sent first.
- Derived: NSYM = ceil(DATAWIDTH/SYMWIDTH); LENW = $clog2(NSYM+1).
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_Data  in  DATAWIDTH  word to serialize.
- i_Len  in  LENW  number of symbols to send, counted from symbol 0; 0 or >NSYM means NSYM.
- i_Valid  in  1  word offered.
- o_Ready  out  1  block accepts a word this cycle.
- o_Sym  out  SYMWIDTH  current symbol.
- o_Valid  out  1  o_Sym valid.
- o_Last  out  1  o_Sym is the final symbol of the word.
- i_Ready  in  1  sink accepts o_Sym this cycle.
- o_Busy  out  1  a word is in progress (state SEND).

## Operation
- Word buffer holds NSYM×SYMWIDTH bits. It is loaded with i_Data zero-extended, so bits above DATAWIDTH in the top symbol are 0.
- Accept: i_Valid && o_Ready at a rising edge latches i_Data and the effective length L, and loads the symbol index.
- Symbol index:
  - MSB_FIRST=0: sequence 0,1,…,L-1.
  - MSB_FIRST=1: sequence L-1,…,0.
  - Symbols at index ≥L are never sent.
- States:
  - IDLE: o_Valid=0, o_Ready=1. On accept, go to SEND and register the first symbol.
  - SEND: o_Valid=1. On i_Ready, advance to the next symbol.
    - On i_Ready while o_Last=1 with no new accept, go to IDLE.
    - On i_Ready while o_Last=1 with i_Valid=1, accept the new word and stay in SEND (back-to-back).
- o_Ready = (state==IDLE) || (o_Valid && o_Last && i_Ready). This is a combinational path from i_Ready to o_Ready; no other combinational input-to-output paths exist.
- o_Last = 1 when the current symbol's position in the sequence is L-1. For L=1, o_Last is set on the first symbol.
- A transfer of L symbols needs exactly L output handshakes. i_Data and i_Len are sampled only at accept.

## Timing
- Reset values: o_Valid=0, o_Last=0, o_Sym=0, o_Busy=0, state IDLE, so o_Ready=1 once reset is applied. Word buffer and counter clear to 0.
- Latency: word accepted at edge N; first symbol has o_Valid=1 from edge N until its handshake.
- Throughput: one symbol per cycle with i_Ready held at 1. Back-to-back words leave no idle cycle between the last symbol of one word and the first of the next.
- Backpressure: while o_Valid && !i_Ready, o_Sym and o_Last hold stable and no state advances.
- Reset asserted mid-word aborts the transfer immediately (asynchronously). All outputs return to reset values, and the remaining symbols are discarded.
- i_Valid in SEND without a last-symbol handshake is ignored because o_Ready=0. The producer must hold the word.

## Test plan
- DATAWIDTH=20, SYMWIDTH=8, MSB_FIRST=0, i_Len=0, i_Data=20'h81234, i_Ready=1 -> o_Sym 34,12,08 on consecutive cycles. o_Last is set only on 08; o_Valid=1 starting the edge after accept.
- Same word with MSB_FIRST=1 -> 08,12,34, o_Last on 34. With i_Len=2 and MSB_FIRST=0 -> 34,12, o_Last on 12.
- Backpressure: i_Ready toggles 1,0,0,1,1 during 20'h81234 -> each symbol is held stable while i_Ready=0. Sequence is still 34,12,08, exactly 3 handshakes.
- Back-to-back: 20'h81234 then 20'h12345 offered continuously -> 34,12,08,45,23,01 with no gap. o_Ready=1 only in the cycle of the 08 handshake.
- Reset mid-word: rstn low after symbol 12 is accepted -> o_Valid, o_Sym, o_Last and o_Busy become 0 immediately, o_Ready=1. The 08 symbol is never emitted, and after reset release a new word serializes correctly.
- Width edge: DATAWIDTH=16, SYMWIDTH=8 (no partial symbol), i_Data=16'hBEEF -> EF,BE with o_Last on BE. i_Len=3 (>NSYM) also gives exactly 2 symbols.
